circ_frame_assembler: RTL and testbench
=======================================

# circ_frame_assembler

Collects the demodulated 8-bit symbol stream from the EFM demodulator into 32-symbol CIRC frames and presents each completed frame, in parallel, to the CIRC input delay stage directly downstream. Per-symbol erasure flags and the frame's subcode symbol travel alongside the frame. Frame sync monitoring with lock/unlock hysteresis gives the later decoder stages a reliability indication.

## Interface
- `WIDTH`, default 8: symbol width in bits.
- `WORDS`, default 32: data symbols per frame (24 audio plus 8 parity).
- `LOCK_N`, default 2: consecutive good frames required to assert `LOCKED`.
- `UNLOCK_N`, default 3: consecutive bad frames required to deassert `LOCKED`.

Ports:
- `CLK` in 1: system clock. Rising edge only.
- `RST` in 1: reset, asynchronous, active-high.
- `SYNC` in 1: one-cycle pulse, frame sync pattern detected.
- `SYM_D` in WIDTH: demodulated symbol.
- `SYM_VALID` in 1: `SYM_D` and `SYM_ERR` are valid this cycle.
- `SYM_ERR` in 1: symbol came from an illegal EFM code (erasure).
- `Q` out [WORDS-1:0][WIDTH-1:0]: assembled frame. Index 0 is the first data symbol after the subcode.
- `ERAS` out WORDS: per-word erasure flags, aligned with `Q`.
- `SUBQ` out WIDTH: subcode symbol of the frame in `Q`.
- `FRAME_STB` out 1: one-cycle pulse, new frame on `Q`/`ERAS`/`SUBQ`.
- `LOCKED` out 1: sync lock status.
- `SHORT_CNT` out 8: saturating count of aborted (short) frames.

## Operation
- States:
  - HUNT: symbols are ignored.
    - `SYNC` → SUB.
  - SUB: the first valid symbol is captured into a subcode holding register (error bit ignored).
    - → DATA.
  - DATA: valid symbols shift into a collection buffer at index `cnt`, and the erasure bit goes to `ERAS`. `cnt` counts 0..WORDS-1.
    - On the WORDS-th symbol → WAIT.
  - WAIT: frame complete.
    - Symbols arriving here are discarded, and the frame is marked bad (overrun).
    - `SYNC` → SUB.
- Frame commit: when the WORDS-th data symbol is accepted, on the next edge:
  - `Q`, `ERAS` and `SUBQ` load from the collection buffer and holding register.
  - `FRAME_STB` pulses.
- Outputs stay stable until the next commit. Aborted frames are never committed.
- `SYNC` in SUB or DATA (short frame):
  - The frame is aborted and counted as bad.
  - `SHORT_CNT` increments, saturating at 255.
  - `cnt` clears and the FSM goes to SUB.
- `SYNC` together with `SYM_VALID` in the same cycle: `SYNC` wins and the symbol is discarded.
- Frame quality:
  - Good = committed with no overrun before the following `SYNC`.
  - Bad = aborted, or overrun occurred.
  - Judged when the next `SYNC` arrives.
- Lock counters:
  - `good_run` and `bad_run` saturate; each clears on the opposite event.
  - `LOCKED` sets when `good_run` reaches LOCK_N and clears when `bad_run` reaches UNLOCK_N.
  - Status only; it does not gate commits.

## Timing
- Reset values:
  - `Q`, `ERAS`, `SUBQ`: 0.
  - `FRAME_STB`, `LOCKED`, `SHORT_CNT`: 0.
  - State HUNT, `cnt` 0, run counters 0.
- Latency: last data symbol accepted at edge N → `FRAME_STB` high in cycle N+1, with `Q` valid in that same cycle.
- `FRAME_STB` is never high on two consecutive cycles.
- The downstream delay stage samples `Q` on `FRAME_STB`.
- `SYM_VALID` may be asserted on back-to-back cycles.
- Reset mid-frame: the partial frame is lost, outputs go to 0 immediately, and the block returns to HUNT.
- `LOCKED` updates on the edge after the `SYNC` that judges the frame.

## Structure
- Shared package `circ_pkg`:
  - `SYM_W = 8`, `FRAME_WORDS = 32`.
  - Typedefs `sym_t` and `frame_t` (`[FRAME_WORDS-1:0] sym_t`).
  - FSM enum `asm_state_t` {HUNT, SUB, DATA, WAIT}.
- One natural sub-module: `circ_sync_lock`, containing the run counters and the `LOCKED` hysteresis. It takes `frame_good`/`frame_bad` pulses from the assembler FSM.

## Test plan
- Reset, then `SYNC`, then 33 valid symbols (subcode 0xA5, data 0x00..0x1F) → `FRAME_STB` one cycle after the 33rd symbol; `Q[0]`=0x00, `Q[31]`=0x1F, `SUBQ`=0xA5, `ERAS`=0.
- Same frame with `SYM_ERR` on data symbols 3 and 30 → `ERAS` = 0x4000_0008; `Q` otherwise unchanged in pattern.
- `SYNC` after only 20 data symbols, then a full frame → no strobe for the short frame; `SHORT_CNT`=1; the next frame commits correctly.
- Two good frames, each closed by `SYNC` → `LOCKED`=1 one cycle after the judging `SYNC`. Then three overrun frames (34 data symbols each) → `LOCKED`=0.
- `SYNC` and `SYM_VALID` in the same cycle with `SYM_D`=0xFF → 0xFF never appears in `SUBQ`; the next valid symbol becomes the subcode.
- Assert `RST` mid-DATA after a prior committed frame → all outputs 0 asynchronously; symbols ignored until `SYNC`; `LOCKED`=0.

Source files
------------

// File: rtl/circ_frame_assembler_pkg.sv
// Shared types and constants for the CIRC frame assembly path.
package circ_pkg;

    localparam int SYM_W       = 8;
    localparam int FRAME_WORDS = 32;

    typedef logic [SYM_W-1:0]       sym_t;
    typedef sym_t [FRAME_WORDS-1:0] frame_t;

    typedef enum logic [1:0] {HUNT, SUB, DATA, WAIT} asm_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/circ_frame_assembler_sync_lock.sv
// Frame-sync lock hysteresis: LOCKED after LOCK_N good frames in a row,
// dropped after UNLOCK_N bad frames in a row.
module circ_sync_lock #(
    parameter int LOCK_N   = 2,
    parameter int UNLOCK_N = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic frame_good_i,
    input  logic frame_bad_i,
    output logic locked_o
);

    logic [7:0] good_run_q, good_run_d;
    logic [7:0] bad_run_q,  bad_run_d;
    logic       locked_q,   locked_d;

    always_comb begin
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        locked_d   = locked_q;
        if (frame_good_i) begin
            good_run_d = (good_run_q >= 8'(LOCK_N)) ? good_run_q : good_run_q + 8'd1;
            bad_run_d  = '0;
        end else if (frame_bad_i) begin
            bad_run_d  = (bad_run_q >= 8'(UNLOCK_N)) ? bad_run_q : bad_run_q + 8'd1;
            good_run_d = '0;
        end
        if (frame_good_i && good_run_d >= 8'(LOCK_N))
            locked_d = 1'b1;
        if (frame_bad_i && bad_run_d >= 8'(UNLOCK_N))
            locked_d = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            good_run_q <= '0;
            bad_run_q  <= '0;
            locked_q   <= 1'b0;
        end else begin
            good_run_q <= good_run_d;
            bad_run_q  <= bad_run_d;
            locked_q   <= locked_d;
        end
    end

    assign locked_o = locked_q;

endmodule

// File: rtl/circ_frame_assembler.sv
// Collects demodulated symbols into CIRC frames (subcode + WORDS data symbols)
// and presents each completed frame in parallel with erasure flags.
module circ_frame_assembler
    import circ_pkg::*;
#(
    parameter int WIDTH    = SYM_W,
    parameter int WORDS    = FRAME_WORDS,
    parameter int LOCK_N   = 2,
    parameter int UNLOCK_N = 3
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        SYNC,
    input  logic [WIDTH-1:0]            SYM_D,
    input  logic                        SYM_VALID,
    input  logic                        SYM_ERR,
    output logic [WORDS-1:0][WIDTH-1:0] Q,
    output logic [WORDS-1:0]            ERAS,
    output logic [WIDTH-1:0]            SUBQ,
    output logic                        FRAME_STB,
    output logic                        LOCKED,
    output logic [7:0]                  SHORT_CNT
);

    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    asm_state_t                 state_q;
    logic [CW-1:0]              cnt_q;
    logic [WORDS-1:0][WIDTH-1:0] buf_q;
    logic [WORDS-1:0]           ebuf_q;
    logic [WIDTH-1:0]           sub_hold_q;
    logic                       commit_q;
    logic                       ovr_q;
    logic                       good_q, bad_q;
    logic [WORDS-1:0][WIDTH-1:0] q_q;
    logic [WORDS-1:0]           eras_q;
    logic [WIDTH-1:0]           subq_q;
    logic                       stb_q;
    logic [7:0]                 short_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= HUNT;
            cnt_q      <= '0;
            buf_q      <= '0;
            ebuf_q     <= '0;
            sub_hold_q <= '0;
            commit_q   <= 1'b0;
            ovr_q      <= 1'b0;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
            q_q        <= '0;
            eras_q     <= '0;
            subq_q     <= '0;
            stb_q      <= 1'b0;
            short_q    <= '0;
        end else begin
            stb_q    <= 1'b0;
            good_q   <= 1'b0;
            bad_q    <= 1'b0;
            commit_q <= 1'b0;
            // Commit one edge after the last data symbol lands in the buffer.
            if (commit_q) begin
                q_q    <= buf_q;
                eras_q <= ebuf_q;
                subq_q <= sub_hold_q;
                stb_q  <= 1'b1;
            end
            case (state_q)
                HUNT: begin
                    if (SYNC)
                        state_q <= SUB;
                end
                SUB: begin
                    if (SYNC) begin
                        bad_q   <= 1'b1;
                        short_q <= sat_inc8(short_q);
                    end else if (SYM_VALID) begin
                        sub_hold_q <= SYM_D;
                        cnt_q      <= '0;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (SYNC) begin
                        bad_q   <= 1'b1;
                        short_q <= sat_inc8(short_q);
                        cnt_q   <= '0;
                        state_q <= SUB;
                    end else if (SYM_VALID) begin
                        buf_q[cnt_q]  <= SYM_D;
                        ebuf_q[cnt_q] <= SYM_ERR;
                        if (cnt_q == CW'(WORDS - 1)) begin
                            commit_q <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= WAIT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (SYNC) begin
                        good_q  <= ~ovr_q;
                        bad_q   <= ovr_q;
                        ovr_q   <= 1'b0;
                        state_q <= SUB;
                    end else if (SYM_VALID) begin
                        ovr_q <= 1'b1;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    circ_sync_lock #(
        .LOCK_N   (LOCK_N),
        .UNLOCK_N (UNLOCK_N)
    ) u_sync_lock (
        .CLK          (CLK),
        .RST          (RST),
        .frame_good_i (good_q),
        .frame_bad_i  (bad_q),
        .locked_o     (LOCKED)
    );

    assign Q         = q_q;
    assign ERAS      = eras_q;
    assign SUBQ      = subq_q;
    assign FRAME_STB = stb_q;
    assign SHORT_CNT = short_q;

endmodule

// File: tb/tb_circ_frame_assembler.sv
// Directed/randomized bench for circ_frame_assembler with a frame-level reference model.
module tb_circ_frame_assembler;

    localparam int W  = 8;
    localparam int N  = 32;
    localparam int LN = 2;
    localparam int UN = 3;

    logic CLK = 1'b0;
    logic RST, SYNC, SYM_VALID, SYM_ERR;
    logic [W-1:0] SYM_D;
    logic [N-1:0][W-1:0] Q;
    logic [N-1:0] ERAS;
    logic [W-1:0] SUBQ;
    logic FRAME_STB, LOCKED;
    logic [7:0] SHORT_CNT;

    int total = 0;
    int bad   = 0;

    // Reference model: frame-level bookkeeping of what was sent since the last SYNC.
    int  m_ph;      // -1: hunting, 0: expecting subcode, k>0: k-1 data symbols received
    bit  m_com, m_ovr, m_lock;
    int  m_short;
    bit  hist[$];   // judged frame quality, 1 = good
    logic [N-1:0][W-1:0] cur_q, exp_q;
    logic [N-1:0]        cur_e, exp_e;
    logic [W-1:0]        cur_s, exp_s;

    always #5 CLK = ~CLK;

    circ_frame_assembler #(
        .WIDTH    (W),
        .WORDS    (N),
        .LOCK_N   (LN),
        .UNLOCK_N (UN)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SYNC      (SYNC),
        .SYM_D     (SYM_D),
        .SYM_VALID (SYM_VALID),
        .SYM_ERR   (SYM_ERR),
        .Q         (Q),
        .ERAS      (ERAS),
        .SUBQ      (SUBQ),
        .FRAME_STB (FRAME_STB),
        .LOCKED    (LOCKED),
        .SHORT_CNT (SHORT_CNT)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        m_ph = -1; m_com = 0; m_ovr = 0; m_lock = 0; m_short = 0;
        hist.delete();
        exp_q = '0; exp_e = '0; exp_s = '0;
        cur_q = '0; cur_e = '0; cur_s = '0;
    endtask

    function automatic bit last_all(input int n, input bit v);
        if (hist.size() < n) return 1'b0;
        for (int i = 0; i < n; i++)
            if (hist[hist.size()-1-i] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_outs(input string tag);
        check({tag, "_q"},    Q,    exp_q);
        check({tag, "_eras"}, ERAS, exp_e);
        check({tag, "_subq"}, SUBQ, exp_s);
    endtask

    task automatic do_sync(input bit with_sym);
        bit old_lock;
        old_lock  = m_lock;
        SYNC      = 1'b1;
        SYM_VALID = with_sym;
        SYM_D     = 8'hFF;
        SYM_ERR   = 1'b0;
        tick();
        SYNC      = 1'b0;
        SYM_VALID = 1'b0;
        if (m_ph != -1) begin
            hist.push_back(m_com && !m_ovr);
            if (!m_com && m_short < 255) m_short++;
            if (last_all(LN, 1'b1))      m_lock = 1'b1;
            else if (last_all(UN, 1'b0)) m_lock = 1'b0;
        end
        m_ph = 0; m_com = 0; m_ovr = 0;
        check("lock_before_update", LOCKED, old_lock);
        tick();
        check("lock", LOCKED, m_lock);
        check("short_cnt", SHORT_CNT, m_short);
        check("stb_idle", FRAME_STB, 1'b0);
        check_outs("stable");
    endtask

    task automatic send_sym(input logic [W-1:0] d, input bit e);
        int idx;
        if ($urandom_range(3) == 0) tick();
        SYM_VALID = 1'b1;
        SYM_D     = d;
        SYM_ERR   = e;
        tick();
        SYM_VALID = 1'b0;
        SYM_ERR   = 1'b0;
        if (m_ph == -1) begin
            check("hunt_stb", FRAME_STB, 1'b0);
        end else if (m_ph == 0) begin
            cur_s = d;
            m_ph  = 1;
        end else begin
            idx = m_ph - 1;
            if (idx < N) begin
                cur_q[idx] = d;
                cur_e[idx] = e;
            end else begin
                m_ovr = 1'b1;
            end
            m_ph++;
            if (idx == N - 1) begin
                check("stb_early", FRAME_STB, 1'b0);
                exp_q = cur_q; exp_e = cur_e; exp_s = cur_s; m_com = 1'b1;
                tick();
                check("stb", FRAME_STB, 1'b1);
                check_outs("commit");
                tick();
                check("stb_pulse", FRAME_STB, 1'b0);
                check_outs("hold");
            end
        end
    endtask

    task automatic send_frame(input logic [W-1:0] sub, input int ndata, input bit seq,
                              input logic [N-1:0] errs);
        send_sym(sub, 1'($urandom_range(1)));
        for (int i = 0; i < ndata; i++)
            send_sym(seq ? W'(i) : W'($urandom), (i < N) ? errs[i] : 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; SYNC = 1'b0; SYM_VALID = 1'b0; SYM_D = '0; SYM_ERR = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_q", Q, '0);
        check("rst_eras", ERAS, '0);
        check("rst_subq", SUBQ, '0);
        check("rst_stb", FRAME_STB, 1'b0);
        check("rst_lock", LOCKED, 1'b0);
        check("rst_short", SHORT_CNT, '0);
        @(negedge CLK);
        RST = 1'b0;
        tick();

        // Sequential pattern frame with subcode A5
        do_sync(1'b0);
        send_frame(8'hA5, N, 1'b1, '0);
        check("q0", Q[0], 8'h00);
        check("q31", Q[31], 8'h1F);

        // Erasures on data symbols 3 and 30
        do_sync(1'b0);
        send_frame(8'hA5, N, 1'b1, 32'h4000_0008);
        check("eras_pattern", ERAS, 32'h4000_0008);

        // Short frame then a full random frame
        do_sync(1'b0);
        send_frame(W'($urandom), 20, 1'b0, '0);
        do_sync(1'b0);
        check("short_one", SHORT_CNT, 8'd1);
        send_frame(W'($urandom), N, 1'b0, N'($urandom));

        // Good frames keep / establish lock
        do_sync(1'b0);
        send_frame(W'($urandom), N, 1'b0, N'($urandom));
        do_sync(1'b0);
        check("locked_after_good", LOCKED, 1'b1);

        // Three overrun frames drop lock
        for (int k = 0; k < 3; k++) begin
            send_frame(W'($urandom), N + 2, 1'b0, N'($urandom));
            do_sync(1'b0);
        end
        check("unlocked_after_overrun", LOCKED, 1'b0);

        // SYNC with a coincident valid symbol: that symbol is discarded
        send_frame(W'($urandom), N, 1'b0, N'($urandom));
        do_sync(1'b1);
        send_frame(W'($urandom_range(8'hFE)), N, 1'b0, N'($urandom));
        check("subq_not_ff", SUBQ == 8'hFF, 1'b0);

        // Asynchronous reset in the middle of a frame
        do_sync(1'b0);
        send_sym(W'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) send_sym(W'($urandom), 1'b0);
        #3;
        RST = 1'b1;
        #1;
        model_reset();
        check("arst_q", Q, '0);
        check("arst_eras", ERAS, '0);
        check("arst_subq", SUBQ, '0);
        check("arst_stb", FRAME_STB, 1'b0);
        check("arst_lock", LOCKED, 1'b0);
        check("arst_short", SHORT_CNT, '0);
        @(negedge CLK);
        RST = 1'b0;
        tick();
        for (int i = 0; i < 40; i++) send_sym(W'($urandom), 1'($urandom_range(1)));
        check("hunt_q", Q, '0);
        do_sync(1'b0);
        send_frame(W'($urandom), N, 1'b0, N'($urandom));
        check("lock_after_reset", LOCKED, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
